ll_head_table_ctrl: RTL and testbench

- Command front-end and head-table owner for the linked-list engine; it is the initiator on the engine's cmd/res interface and the sink of its head-table write port.
- Accepts user commands addressed by bucket and looks up that bucket's head pointer in an internal head table.
- Issues one command to the engine with head_ptr/head_ptr_val, applies the engine's head-table update, then returns the result to the user.
- Exactly one command is outstanding at a time, so there are no bucket hazards.

---
 rtl/ll_head_table_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_ll_head_table_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ll_head_table_ctrl.sv
// ll_head_table_ctrl: command front-end and head-table owner for the linked-list engine.
// Looks up a bucket's head pointer, issues one engine command at a time, applies the
// engine's head-table update inside the command/result window, and returns the result.
module ll_head_table_ctrl #(
  parameter int         KEY_WIDTH    = 32,
  parameter int         PTR_WIDTH    = 10,
  parameter int         BUCKET_WIDTH = 8,
  parameter logic [2:0] RES_ILLEGAL  = 3'd7
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    usr_cmd_valid_i,
  output logic                    usr_cmd_ready_o,
  input  logic [BUCKET_WIDTH-1:0] usr_cmd_bucket_i,
  input  logic [KEY_WIDTH-1:0]    usr_cmd_key_i,
  input  logic [1:0]              usr_cmd_opcode_i,
  output logic                    usr_res_valid_o,
  input  logic                    usr_res_ready_i,
  output logic [BUCKET_WIDTH-1:0] usr_res_bucket_o,
  output logic [KEY_WIDTH-1:0]    usr_res_key_o,
  output logic [1:0]              usr_res_opcode_o,
  output logic [2:0]              usr_res_rescode_o,
  output logic [2:0]              usr_res_chain_state_o,
  output logic                    ll_cmd_valid_o,
  input  logic                    ll_cmd_ready_i,
  output logic [KEY_WIDTH-1:0]    ll_cmd_key_o,
  output logic [1:0]              ll_cmd_opcode_o,
  output logic [PTR_WIDTH-1:0]    ll_cmd_head_ptr_o,
  output logic                    ll_cmd_head_ptr_val_o,
  input  logic                    ll_res_valid_i,
  output logic                    ll_res_ready_o,
  input  logic [KEY_WIDTH-1:0]    ll_res_key_i,
  input  logic [1:0]              ll_res_opcode_i,
  input  logic [2:0]              ll_res_rescode_i,
  input  logic [2:0]              ll_res_chain_state_i,
  input  logic [PTR_WIDTH-1:0]    ht_wr_data_ptr_i,
  input  logic                    ht_wr_data_ptr_val_i,
  input  logic                    ht_wr_en_i,
  input  logic                    clear_run_i,
  output logic                    clear_done_o,
  output logic                    err_o
);

  localparam int DEPTH = 1 << BUCKET_WIDTH;
  localparam int ENT_W = PTR_WIDTH + 1;
  localparam logic [BUCKET_WIDTH-1:0] CNT_LAST     = '1;
  localparam logic [BUCKET_WIDTH-1:0] CNT_PRE_LAST = CNT_LAST - 1'b1;
  localparam logic [1:0] OP_INSERT = 2'd0;
  localparam logic [1:0] OP_DELETE = 2'd1;
  localparam logic [1:0] OP_DEQ    = 2'd2;

  typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_ILL, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t                  state_q;
  logic [BUCKET_WIDTH-1:0] cnt_q;
  logic [BUCKET_WIDTH-1:0] bucket_q;
  logic [KEY_WIDTH-1:0]    key_q;
  logic [1:0]              opcode_q;
  logic                    usr_cmd_ready_q;
  logic                    ll_cmd_valid_q;
  logic                    ll_res_ready_q;
  logic                    usr_res_valid_q;
  logic [KEY_WIDTH-1:0]    res_key_q;
  logic [1:0]              res_opcode_q;
  logic [2:0]              res_rescode_q;
  logic [2:0]              res_chain_q;
  logic                    clear_done_q;
  logic                    err_q;

  // Head table {val, ptr}; contents are not reset, the CLEAR walk zeroes them.
  logic [ENT_W-1:0]        mem [DEPTH];
  logic [ENT_W-1:0]        rd_q;
  logic                    mem_we;
  logic [BUCKET_WIDTH-1:0] mem_waddr;
  logic [ENT_W-1:0]        mem_wdata;

  logic usr_cmd_hs, ll_cmd_hs, ll_res_hs, usr_res_hs, legal_op, wr_window;

  assign usr_cmd_hs = usr_cmd_valid_i & usr_cmd_ready_q;
  assign ll_cmd_hs  = ll_cmd_valid_q & ll_cmd_ready_i;
  assign ll_res_hs  = ll_res_valid_i & ll_res_ready_q;
  assign usr_res_hs = usr_res_valid_q & usr_res_ready_i;
  assign legal_op   = (usr_cmd_opcode_i == OP_INSERT) || (usr_cmd_opcode_i == OP_DELETE) ||
                      (usr_cmd_opcode_i == OP_DEQ);
  // Window opens on the command handshake and stays open through the result handshake
  // (ll_res_ready_q is high exactly while waiting for the result).
  assign wr_window  = ll_cmd_hs | ll_res_ready_q;

  // Table write port: clear walk has priority; engine updates only land inside the window.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = bucket_q;
    mem_wdata = {ht_wr_data_ptr_val_i, ht_wr_data_ptr_i};
    if (state_q == S_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
      mem_wdata = '0;
    end else if (ht_wr_en_i && wr_window) begin
      mem_we = 1'b1;
    end
  end

  // Table storage with registered read, sampled on the user command handshake.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (usr_cmd_hs) rd_q <= mem[usr_cmd_bucket_i];
  end

  // Main control FSM with registered handshake outputs and sticky error.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= S_CLEAR;
      cnt_q           <= '0;
      bucket_q        <= '0;
      key_q           <= '0;
      opcode_q        <= '0;
      usr_cmd_ready_q <= 1'b0;
      ll_cmd_valid_q  <= 1'b0;
      ll_res_ready_q  <= 1'b0;
      usr_res_valid_q <= 1'b0;
      res_key_q       <= '0;
      res_opcode_q    <= '0;
      res_rescode_q   <= '0;
      res_chain_q     <= '0;
      clear_done_q    <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      clear_done_q <= 1'b0;
      if (ht_wr_en_i && !wr_window) err_q <= 1'b1;
      case (state_q)
        S_CLEAR: begin
          cnt_q <= cnt_q + 1'b1;
          // Pulse lines up with the cycle that writes the last entry.
          if (cnt_q == CNT_PRE_LAST) clear_done_q <= 1'b1;
          if (cnt_q == CNT_LAST) begin
            cnt_q           <= '0;
            state_q         <= S_IDLE;
            usr_cmd_ready_q <= 1'b1;
          end
        end
        S_IDLE: begin
          // A command accepted in the same cycle wins over a clear request, since the
          // user already saw ready high.
          if (usr_cmd_hs) begin
            usr_cmd_ready_q <= 1'b0;
            bucket_q        <= usr_cmd_bucket_i;
            key_q           <= usr_cmd_key_i;
            opcode_q        <= usr_cmd_opcode_i;
            if (legal_op) begin
              ll_cmd_valid_q <= 1'b1;
              state_q        <= S_ISSUE;
            end else begin
              state_q <= S_ILL;
            end
          end else if (clear_run_i) begin
            usr_cmd_ready_q <= 1'b0;
            cnt_q           <= '0;
            state_q         <= S_CLEAR;
          end
        end
        S_ILL: begin
          usr_res_valid_q <= 1'b1;
          res_key_q       <= key_q;
          res_opcode_q    <= opcode_q;
          res_rescode_q   <= RES_ILLEGAL;
          res_chain_q     <= '0;
          state_q         <= S_RESP;
        end
        S_ISSUE: begin
          if (ll_cmd_hs) begin
            ll_cmd_valid_q <= 1'b0;
            ll_res_ready_q <= 1'b1;
            state_q        <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (ll_res_hs) begin
            ll_res_ready_q  <= 1'b0;
            usr_res_valid_q <= 1'b1;
            res_key_q       <= ll_res_key_i;
            res_opcode_q    <= ll_res_opcode_i;
            res_rescode_q   <= ll_res_rescode_i;
            res_chain_q     <= ll_res_chain_state_i;
            if (ll_res_key_i != key_q) err_q <= 1'b1;
            state_q <= S_RESP;
          end
        end
        S_RESP: begin
          if (usr_res_hs) begin
            usr_res_valid_q <= 1'b0;
            usr_cmd_ready_q <= 1'b1;
            state_q         <= S_IDLE;
          end
        end
        default: state_q <= S_CLEAR;
      endcase
    end
  end

  assign usr_cmd_ready_o       = usr_cmd_ready_q;
  assign usr_res_valid_o       = usr_res_valid_q;
  assign usr_res_bucket_o      = bucket_q;
  assign usr_res_key_o         = res_key_q;
  assign usr_res_opcode_o      = res_opcode_q;
  assign usr_res_rescode_o     = res_rescode_q;
  assign usr_res_chain_state_o = res_chain_q;
  assign ll_cmd_valid_o        = ll_cmd_valid_q;
  assign ll_cmd_key_o          = key_q;
  assign ll_cmd_opcode_o       = opcode_q;
  // The table read register has no reset, so the head fields are qualified by valid.
  assign ll_cmd_head_ptr_o     = ll_cmd_valid_q ? rd_q[PTR_WIDTH-1:0] : '0;
  assign ll_cmd_head_ptr_val_o = ll_cmd_valid_q & rd_q[PTR_WIDTH];
  assign ll_res_ready_o        = ll_res_ready_q;
  assign clear_done_o          = clear_done_q;
  assign err_o                 = err_q;

endmodule

// File: tb/tb_ll_head_table_ctrl.sv
// tb_ll_head_table_ctrl: randomized transactions against a transaction-level model of the
// head table, with per-cycle output comparison and a few literal checks.
module tb_ll_head_table_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        usr_cmd_valid_i = 1'b0, usr_cmd_ready_o;
  logic [3:0]  usr_cmd_bucket_i = '0;
  logic [31:0] usr_cmd_key_i = '0;
  logic [1:0]  usr_cmd_opcode_i = '0;
  logic        usr_res_valid_o, usr_res_ready_i = 1'b0;
  logic [3:0]  usr_res_bucket_o;
  logic [31:0] usr_res_key_o;
  logic [1:0]  usr_res_opcode_o;
  logic [2:0]  usr_res_rescode_o, usr_res_chain_state_o;
  logic        ll_cmd_valid_o, ll_cmd_ready_i = 1'b0;
  logic [31:0] ll_cmd_key_o;
  logic [1:0]  ll_cmd_opcode_o;
  logic [9:0]  ll_cmd_head_ptr_o;
  logic        ll_cmd_head_ptr_val_o;
  logic        ll_res_valid_i = 1'b0, ll_res_ready_o;
  logic [31:0] ll_res_key_i = '0;
  logic [1:0]  ll_res_opcode_i = '0;
  logic [2:0]  ll_res_rescode_i = '0, ll_res_chain_state_i = '0;
  logic [9:0]  ht_wr_data_ptr_i = '0;
  logic        ht_wr_data_ptr_val_i = 1'b0, ht_wr_en_i = 1'b0;
  logic        clear_run_i = 1'b0, clear_done_o, err_o;

  ll_head_table_ctrl #(.KEY_WIDTH(32), .PTR_WIDTH(10), .BUCKET_WIDTH(4), .RES_ILLEGAL(3'd7)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .usr_cmd_valid_i(usr_cmd_valid_i), .usr_cmd_ready_o(usr_cmd_ready_o),
    .usr_cmd_bucket_i(usr_cmd_bucket_i), .usr_cmd_key_i(usr_cmd_key_i),
    .usr_cmd_opcode_i(usr_cmd_opcode_i),
    .usr_res_valid_o(usr_res_valid_o), .usr_res_ready_i(usr_res_ready_i),
    .usr_res_bucket_o(usr_res_bucket_o), .usr_res_key_o(usr_res_key_o),
    .usr_res_opcode_o(usr_res_opcode_o), .usr_res_rescode_o(usr_res_rescode_o),
    .usr_res_chain_state_o(usr_res_chain_state_o),
    .ll_cmd_valid_o(ll_cmd_valid_o), .ll_cmd_ready_i(ll_cmd_ready_i),
    .ll_cmd_key_o(ll_cmd_key_o), .ll_cmd_opcode_o(ll_cmd_opcode_o),
    .ll_cmd_head_ptr_o(ll_cmd_head_ptr_o), .ll_cmd_head_ptr_val_o(ll_cmd_head_ptr_val_o),
    .ll_res_valid_i(ll_res_valid_i), .ll_res_ready_o(ll_res_ready_o),
    .ll_res_key_i(ll_res_key_i), .ll_res_opcode_i(ll_res_opcode_i),
    .ll_res_rescode_i(ll_res_rescode_i), .ll_res_chain_state_i(ll_res_chain_state_i),
    .ht_wr_data_ptr_i(ht_wr_data_ptr_i), .ht_wr_data_ptr_val_i(ht_wr_data_ptr_val_i),
    .ht_wr_en_i(ht_wr_en_i), .clear_run_i(clear_run_i),
    .clear_done_o(clear_done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(negedge clk_i) cyc++;

  int total = 0, bad = 0;
  int n_legal = 0, n_txn = 0, cmd_hs_n = 0, res_hs_n = 0;
  int rise_cyc = 0;
  logic [2:0] rise_rc = '0;
  logic res_v_prev = 1'b0;

  // Model: head table contents and the expected value of every output for this cycle.
  logic [10:0] model_tbl [16];
  logic        exp_cmd_ready = 0, exp_cmd_valid = 0, exp_res_ready = 0, exp_res_valid = 0;
  logic        exp_clear_done = 0, exp_err = 0;
  logic [31:0] exp_cmd_key = 0, exp_res_key = 0;
  logic [1:0]  exp_cmd_op = 0, exp_res_op = 0;
  logic [9:0]  exp_cmd_ptr = 0;
  logic        exp_cmd_pv = 0;
  logic [3:0]  exp_res_bucket = 0;
  logic [2:0]  exp_rc = 0, exp_cs = 0;
  logic [9:0]  seen_ptr = 0;
  logic        seen_pv = 0;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Per-cycle comparison of DUT outputs against the model.
  initial forever begin
    @(posedge clk_i); #1;
    check("usr_cmd_ready", usr_cmd_ready_o, exp_cmd_ready);
    check("ll_cmd_valid", ll_cmd_valid_o, exp_cmd_valid);
    check("ll_res_ready", ll_res_ready_o, exp_res_ready);
    check("usr_res_valid", usr_res_valid_o, exp_res_valid);
    check("clear_done", clear_done_o, exp_clear_done);
    check("err", err_o, exp_err);
    if (exp_cmd_valid) begin
      check("ll_cmd_key", ll_cmd_key_o, exp_cmd_key);
      check("ll_cmd_op", ll_cmd_opcode_o, exp_cmd_op);
      check("ll_cmd_head_ptr", ll_cmd_head_ptr_o, exp_cmd_ptr);
      check("ll_cmd_head_val", ll_cmd_head_ptr_val_o, exp_cmd_pv);
    end
    if (exp_res_valid) begin
      check("usr_res_bucket", usr_res_bucket_o, exp_res_bucket);
      check("usr_res_key", usr_res_key_o, exp_res_key);
      check("usr_res_op", usr_res_opcode_o, exp_res_op);
      check("usr_res_rescode", usr_res_rescode_o, exp_rc);
      check("usr_res_chain", usr_res_chain_state_o, exp_cs);
    end
  end

  // Result-valid rising edge capture, for latency literals.
  initial forever begin
    @(posedge clk_i); #1;
    if (usr_res_valid_o && !res_v_prev) begin
      rise_cyc = cyc;
      rise_rc  = usr_res_rescode_o;
    end
    res_v_prev = usr_res_valid_o;
  end

  // Handshake counters.
  always @(posedge clk_i) begin
    if (ll_cmd_valid_o && ll_cmd_ready_i) cmd_hs_n++;
    if (usr_res_valid_o && usr_res_ready_i) res_hs_n++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  // Clear walk of 16 entries starting with the next edge.
  task automatic wait_clear();
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk_i);
      exp_clear_done = (i == 15);
      exp_cmd_ready  = (i == 16);
    end
    @(negedge clk_i);
    for (int i = 0; i < 16; i++) model_tbl[i] = '0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    exp_cmd_ready = 0; exp_cmd_valid = 0; exp_res_ready = 0;
    exp_res_valid = 0; exp_clear_done = 0; exp_err = 0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    wait_clear();
  endtask

  // Random head-table update for this cycle; the model follows accepted writes.
  task automatic drive_wr(input logic [3:0] b, input bit en);
    logic [9:0] p;
    logic       v;
    p = 10'($urandom);
    v = 1'($urandom);
    ht_wr_en_i = en; ht_wr_data_ptr_i = p; ht_wr_data_ptr_val_i = v;
    if (en) model_tbl[b] = {v, p};
  endtask

  // One complete user transaction; starts and ends at a negedge with the DUT idle.
  task automatic run_txn(input logic [3:0] b, input logic [31:0] k, input logic [1:0] op,
                         input int cmd_stall, input int res_lat, input int usr_stall,
                         input bit force_wr, input logic [9:0] fptr, input logic fval,
                         input bit bad_key, input bit clr_issue, output int lat);
    logic [10:0] ent;
    logic [31:0] rkey;
    logic [2:0]  rc, cs;
    int          hs_cyc;
    ent = model_tbl[b];
    usr_cmd_valid_i = 1'b1; usr_cmd_bucket_i = b; usr_cmd_key_i = k; usr_cmd_opcode_i = op;
    @(posedge clk_i);
    hs_cyc = cyc;
    exp_cmd_ready  = 0;
    exp_res_bucket = b;
    n_txn++;
    if (op == 2'b11) begin
      @(negedge clk_i);
      usr_cmd_valid_i = 1'b0;
      @(posedge clk_i);
      exp_res_valid = 1; exp_res_key = k; exp_res_op = op; exp_rc = 3'd7; exp_cs = 3'd0;
    end else begin
      n_legal++;
      exp_cmd_valid = 1; exp_cmd_key = k; exp_cmd_op = op;
      exp_cmd_ptr = ent[9:0]; exp_cmd_pv = ent[10];
      @(negedge clk_i);
      usr_cmd_valid_i = 1'b0;
      repeat (cmd_stall) begin
        clear_run_i = clr_issue;
        @(posedge clk_i);
        @(negedge clk_i);
      end
      clear_run_i = 1'b0;
      ll_cmd_ready_i = 1'b1;
      seen_ptr = ll_cmd_head_ptr_o;
      seen_pv  = ll_cmd_head_ptr_val_o;
      drive_wr(b, 1'($urandom));
      @(posedge clk_i);
      exp_cmd_valid = 0; exp_res_ready = 1;
      @(negedge clk_i);
      ll_cmd_ready_i = 1'b0;
      repeat (res_lat) begin
        drive_wr(b, 1'($urandom));
        @(posedge clk_i);
        @(negedge clk_i);
      end
      rkey = bad_key ? ~k : k;
      rc = 3'($urandom); cs = 3'($urandom);
      ll_res_valid_i = 1'b1; ll_res_key_i = rkey; ll_res_opcode_i = op;
      ll_res_rescode_i = rc; ll_res_chain_state_i = cs;
      if (force_wr) begin
        ht_wr_en_i = 1'b1; ht_wr_data_ptr_i = fptr; ht_wr_data_ptr_val_i = fval;
        model_tbl[b] = {fval, fptr};
      end else begin
        drive_wr(b, 1'($urandom));
      end
      @(posedge clk_i);
      exp_res_ready = 0;
      exp_res_valid = 1; exp_res_key = rkey; exp_res_op = op; exp_rc = rc; exp_cs = cs;
      if (bad_key) exp_err = 1;
    end
    @(negedge clk_i);
    ll_res_valid_i = 1'b0; ht_wr_en_i = 1'b0; ll_cmd_ready_i = 1'b0;
    lat = rise_cyc - hs_cyc + 1;
    repeat (usr_stall) begin
      @(posedge clk_i);
      @(negedge clk_i);
    end
    usr_res_ready_i = 1'b1;
    @(posedge clk_i);
    exp_res_valid = 0; exp_cmd_ready = 1;
    @(negedge clk_i);
    usr_res_ready_i = 1'b0;
    $display("txn %0d bucket=%0d op=%0d key=%h head=%0d/%0d lat=%0d",
             n_txn, b, op, k, exp_cmd_pv, exp_cmd_ptr, lat);
  endtask

  initial begin
    int lat;
    logic [3:0] b;
    logic [1:0] op;
    for (int i = 0; i < 16; i++) model_tbl[i] = '0;

    // Reset release and initial clear walk.
    do_reset();

    // INSERT on empty bucket 3, engine installs head 5; second INSERT must see it.
    run_txn(4'd3, 32'h55, 2'd0, 0, 0, 0, 1'b1, 10'd5, 1'b1, 1'b0, 1'b0, lat);
    check("ins1_head_val", seen_pv, 1'b0);
    check("min_latency", lat, 3);
    run_txn(4'd3, 32'h56, 2'd0, 0, 1, 0, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, lat);
    check("ins2_head_ptr", seen_ptr, 10'd5);
    check("ins2_head_val", seen_pv, 1'b1);

    // Stalled engine command and stalled user result; clear_run during ISSUE is ignored.
    run_txn(4'd9, 32'hA5A5_0001, 2'd1, 4, 2, 3, 1'b0, 10'd0, 1'b0, 1'b0, 1'b1, lat);

    // Bucket 7: insert, delete last element (val=0), DEQ must see an empty head.
    run_txn(4'd7, 32'h77, 2'd0, 0, 0, 0, 1'b1, 10'd9, 1'b1, 1'b0, 1'b0, lat);
    run_txn(4'd7, 32'h77, 2'd1, 1, 0, 0, 1'b1, 10'd9, 1'b0, 1'b0, 1'b0, lat);
    run_txn(4'd7, 32'h78, 2'd2, 0, 0, 0, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, lat);
    check("deq7_head_val", seen_pv, 1'b0);

    // Illegal opcode answered locally.
    run_txn(4'd2, 32'hDEAD, 2'b11, 0, 0, 1, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, lat);
    check("illegal_latency", lat, 2);
    check("illegal_rescode", rise_rc, 3'd7);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      b  = 4'($urandom);
      op = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      run_txn(b, $urandom, op, $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, lat);
    end

    // Clear on request from IDLE: table re-zeroed.
    @(negedge clk_i);
    clear_run_i = 1'b1;
    @(posedge clk_i);
    exp_cmd_ready = 0;
    @(negedge clk_i);
    clear_run_i = 1'b0;
    wait_clear();
    run_txn(4'd3, 32'h1234, 2'd2, 0, 0, 0, 1'b1, 10'd33, 1'b1, 1'b0, 1'b0, lat);
    check("post_clear_head_val", seen_pv, 1'b0);

    // Head-table write outside the window: ignored, sets the sticky error.
    @(negedge clk_i);
    ht_wr_en_i = 1'b1; ht_wr_data_ptr_i = 10'h3A; ht_wr_data_ptr_val_i = 1'b0;
    @(posedge clk_i);
    exp_err = 1;
    @(negedge clk_i);
    ht_wr_en_i = 1'b0;
    run_txn(4'd3, 32'h1235, 2'd2, 0, 0, 0, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, lat);
    check("idle_wr_ignored_ptr", seen_ptr, 10'd33);
    check("idle_wr_ignored_val", seen_pv, 1'b1);

    // Reset clears the error and the table; a key mismatch from the engine sets err.
    do_reset();
    run_txn(4'd3, 32'h99, 2'd0, 0, 0, 0, 1'b0, 10'd0, 1'b0, 1'b1, 1'b0, lat);
    check("post_reset_head_val", seen_pv, 1'b0);

    check("cmd_hs_count", cmd_hs_n, n_legal);
    check("res_hs_count", res_hs_n, n_txn);
    repeat (2) @(negedge clk_i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
